// File: rtl/im_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// state encoding, word type and the big-endian byte-lane select.
package im_loader_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_RUN   = 3'd4,
      ST_FULL  = 3'd5
   } state_e;

   localparam int WORD_BYTES = 4;

   // Big-endian lane select: byte 0 is the most significant byte of the word.
   function automatic logic [7:0] be_byte_lane(input word_t word, input logic [1:0] idx);
      logic [7:0] lane;
      case (idx)
         2'd0:    lane = word[31:24];
         2'd1:    lane = word[23:16];
         2'd2:    lane = word[15:8];
         2'd3:    lane = word[7:0];
         default: lane = 8'h00;
      endcase
      return lane;
   endfunction

   // The loader reports busy while an image is in flight (receive, write or release hold).
   function automatic logic state_is_busy(input state_e st);
      logic b;
      case (st)
         ST_RECV, ST_WRITE, ST_HOLD: b = 1'b1;
         default:                    b = 1'b0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/im_loader_if.sv
// Instruction-word stream into the loader: valid/ready handshake with a
// last-word marker. The source is the master, the loader the slave.
interface im_loader_if;
   import im_loader_pkg::*;

   logic  in_valid;
   word_t in_data;
   logic  in_last;
   logic  in_ready;

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      output in_ready
   );

endinterface

// File: rtl/im_loader.sv
// Boot-time instruction-memory writer. Accepts 32-bit words from a stream,
// writes them byte-serially big-endian from IM address 0, keeps the core in
// reset until the image is complete, then releases it after a short hold.
module im_loader
   import im_loader_pkg::*;
#(
   parameter int IM_BYTES    = 1024,
   parameter int ADDR_W      = $clog2(IM_BYTES),
   parameter int HOLD_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start_i,
   im_loader_if.slave        in_if,
   output logic              im_we_o,
   output logic [ADDR_W-1:0] im_addr_o,
   output logic [7:0]        im_wdata_o,
   output logic              cpu_rst_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              overflow_o,
   output logic [ADDR_W-2:0] word_count_o
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   // The word base is one bit wider than the byte address so that reaching
   // the end of memory is visible without wrapping back to zero.
   localparam logic [ADDR_W:0]     MEM_END   = (ADDR_W + 1)'(IM_BYTES);
   localparam logic [ADDR_W:0]     BASE_STEP = (ADDR_W + 1)'(WORD_BYTES);
   localparam logic [ADDR_W-2:0]   WCNT_ONE  = (ADDR_W - 1)'(1);
   localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);

   // Control state
   state_e              state_q, state_d;
   logic [ADDR_W:0]     base_q, base_d;
   logic [1:0]          idx_q, idx_d;
   word_t               data_q, data_d;
   logic                last_q, last_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [ADDR_W-2:0]   wcnt_q, wcnt_d;

   // Registered outputs
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          wdata_q, wdata_d;
   logic                ready_q, ready_d;
   logic                cpu_rst_q, cpu_rst_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_d;

   // Next-state logic: load_start overrides everything, then per-state behaviour.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      idx_d   = idx_q;
      data_d  = data_q;
      last_d  = last_q;
      hold_d  = hold_q;
      wcnt_d  = wcnt_q;

      if (load_start_i) begin
         // Restart abandons any word in flight and begins again at address 0.
         state_d = ST_RECV;
         base_d  = '0;
         idx_d   = 2'd0;
         wcnt_d  = '0;
         hold_d  = '0;
         last_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_RECV: begin
               if (in_if.in_valid && ready_q) begin
                  data_d  = in_if.in_data;
                  last_d  = in_if.in_last;
                  idx_d   = 2'd0;
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_RECV;
               end
            end
            ST_WRITE: begin
               if (idx_q == 2'd3) begin
                  base_d = base_q + BASE_STEP;
                  wcnt_d = wcnt_q + WCNT_ONE;
                  // A last word that exactly fills memory still releases the core.
                  if (last_q) begin
                     state_d = ST_HOLD;
                     hold_d  = HOLD_LOAD;
                  end else if (base_d == MEM_END) begin
                     state_d = ST_FULL;
                  end else begin
                     state_d = ST_RECV;
                  end
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
            ST_HOLD: begin
               if (hold_q == '0) begin
                  state_d = ST_RUN;
               end else begin
                  hold_d = hold_q - HOLD_ONE;
               end
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            ST_FULL: begin
               state_d = ST_FULL;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Output next values are derived from the next state so every output is a flop.
   always_comb begin
      we_d      = (state_d == ST_WRITE);
      ready_d   = (state_d == ST_RECV);
      busy_d    = state_is_busy(state_d);
      done_d    = (state_d == ST_RUN);
      cpu_rst_d = (state_d != ST_RUN);
      ovf_d     = (state_d == ST_FULL);
      addr_d    = addr_q;
      wdata_d   = wdata_q;

      if (state_d == ST_WRITE) begin
         addr_d  = base_d[ADDR_W-1:0] + ADDR_W'(idx_d);
         wdata_d = be_byte_lane(data_d, idx_d);
      end else if (load_start_i) begin
         addr_d  = '0;
         wdata_d = wdata_q;
      end else begin
         addr_d  = addr_q;
         wdata_d = wdata_q;
      end
   end

   // State and output registers; reset drops the write strobe immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         base_q    <= '0;
         idx_q     <= 2'd0;
         data_q    <= '0;
         last_q    <= 1'b0;
         hold_q    <= '0;
         wcnt_q    <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= 8'h00;
         ready_q   <= 1'b0;
         cpu_rst_q <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         wcnt_q    <= wcnt_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         ready_q   <= ready_d;
         cpu_rst_q <= cpu_rst_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
      end
   end

   assign in_if.in_ready = ready_q;
   assign im_we_o        = we_q;
   assign im_addr_o      = addr_q;
   assign im_wdata_o     = wdata_q;
   assign cpu_rst_o      = cpu_rst_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign overflow_o     = ovf_q;
   assign word_count_o   = wcnt_q;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: a default-size instance and a 16-byte instance share
// one stimulus path selected by 'sel'. Expected bytes, addresses and release
// timing come from a simple byte-array model of the image.
module tb_im_loader;
   import im_loader_pkg::*;

   localparam int HOLD = 4;

   logic clk = 1'b0;
   logic rst;
   logic sel;
   logic ls;
   logic vld;
   logic [31:0] dat;
   logic lst;

   always #5 clk = ~clk;

   im_loader_if a_if ();
   im_loader_if b_if ();

   assign a_if.in_valid = vld & ~sel;
   assign a_if.in_data  = dat;
   assign a_if.in_last  = lst;
   assign b_if.in_valid = vld & sel;
   assign b_if.in_data  = dat;
   assign b_if.in_last  = lst;

   logic       a_we, a_crst, a_busy, a_done, a_ovf;
   logic [9:0] a_addr;
   logic [7:0] a_wd;
   logic [8:0] a_wc;
   logic       b_we, b_crst, b_busy, b_done, b_ovf;
   logic [3:0] b_addr;
   logic [7:0] b_wd;
   logic [2:0] b_wc;

   im_loader #(.IM_BYTES(1024), .HOLD_CYCLES(HOLD)) u_dut_a (
      .clk(clk), .rst(rst), .load_start_i(ls & ~sel), .in_if(a_if.slave),
      .im_we_o(a_we), .im_addr_o(a_addr), .im_wdata_o(a_wd), .cpu_rst_o(a_crst),
      .busy_o(a_busy), .done_o(a_done), .overflow_o(a_ovf), .word_count_o(a_wc)
   );

   im_loader #(.IM_BYTES(16), .HOLD_CYCLES(HOLD)) u_dut_b (
      .clk(clk), .rst(rst), .load_start_i(ls & sel), .in_if(b_if.slave),
      .im_we_o(b_we), .im_addr_o(b_addr), .im_wdata_o(b_wd), .cpu_rst_o(b_crst),
      .busy_o(b_busy), .done_o(b_done), .overflow_o(b_ovf), .word_count_o(b_wc)
   );

   // Observed view of whichever instance is selected
   logic       o_we, o_ready, o_crst, o_busy, o_done, o_ovf;
   logic [9:0] o_addr;
   logic [7:0] o_wd;
   logic [8:0] o_wc;
   assign o_we    = sel ? b_we   : a_we;
   assign o_ready = sel ? b_if.in_ready : a_if.in_ready;
   assign o_crst  = sel ? b_crst : a_crst;
   assign o_busy  = sel ? b_busy : a_busy;
   assign o_done  = sel ? b_done : a_done;
   assign o_ovf   = sel ? b_ovf  : a_ovf;
   assign o_addr  = sel ? {6'd0, b_addr} : a_addr;
   assign o_wd    = sel ? b_wd   : a_wd;
   assign o_wc    = sel ? {6'd0, b_wc} : a_wc;

   // Instruction memories written by the loaders
   logic [7:0] mem_a [0:1023];
   logic [7:0] mem_b [0:15];
   always @(posedge clk) begin
      if (a_we) mem_a[a_addr] <= a_wd;
      if (b_we) mem_b[b_addr] <= b_wd;
   end

   // Reference image contents
   logic [7:0] exp_a [0:1023];
   logic [7:0] exp_b [0:15];

   int n_chk = 0;
   int n_err = 0;

   function automatic logic [7:0] dut_mem(input int a);
      logic [9:0] ad;
      ad = 10'(a);
      if (sel) return mem_b[ad[3:0]];
      else     return mem_a[ad];
   endfunction

   function automatic logic [7:0] exp_mem(input int a);
      logic [9:0] ad;
      ad = 10'(a);
      if (sel) return exp_b[ad[3:0]];
      else     return exp_a[ad];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_load();
      vld = 1'b0;
      @(negedge clk);
      ls = 1'b1;
      @(negedge clk);
      ls = 1'b0;
      chk("start_cpu_rst", 32'(o_crst), 32'd1);
      chk("start_done", 32'(o_done), 32'd0);
      chk("start_overflow", 32'(o_ovf), 32'd0);
      chk("start_word_count", 32'(o_wc), 32'd0);
      chk("start_in_ready", 32'(o_ready), 32'd1);
   endtask

   // Offer one word (optionally with valid toggling) and follow its byte writes.
   // phase 0: valid held high; 1/2: valid alternates starting low/high.
   task automatic send_word(input logic [31:0] w, input bit last, input int phase,
                            input int widx, input int nbytes);
      int cyc;
      bit hs;
      int ba;
      cyc = 0;
      hs  = 1'b0;
      dat = w;
      lst = last;
      while (!hs && cyc < 40) begin
         vld = (phase == 0) ? 1'b1 : (((cyc + phase) % 2) == 0);
         hs  = vld && o_ready;
         @(negedge clk);
         cyc++;
      end
      vld = 1'b0;
      lst = 1'b0;
      chk("handshake", 32'(hs), 32'd1);
      for (int i = 0; i < nbytes; i++) begin
         if (i > 0) @(negedge clk);
         ba = widx * 4 + i;
         chk("im_we", 32'(o_we), 32'd1);
         chk("im_addr", 32'(o_addr), 32'(ba));
         chk("im_wdata", 32'(o_wd), (w >> (8 * (3 - i))) & 32'hff);
         chk("ready_in_write", 32'(o_ready), 32'd0);
         if (sel) exp_b[ba % 16] = 8'((w >> (8 * (3 - i))) & 32'hff);
         else     exp_a[ba]      = 8'((w >> (8 * (3 - i))) & 32'hff);
      end
      if (nbytes == 4) begin
         @(negedge clk);
         chk("im_we_after", 32'(o_we), 32'd0);
         chk("word_count", 32'(o_wc), 32'(widx + 1));
      end
   endtask

   task automatic load_words(input int n, input bit flag_last, input int phase,
                             input bit fixed, input logic [31:0] w0);
      logic [31:0] w;
      start_load();
      for (int k = 0; k < n; k++) begin
         w = (fixed && k == 0) ? w0 : $urandom();
         send_word(w, flag_last && (k == n - 1), phase, k, 4);
      end
      if (flag_last) begin
         for (int h = 0; h <= HOLD; h++) begin
            chk("hold_cpu_rst", 32'(o_crst), 32'd1);
            chk("hold_done", 32'(o_done), 32'd0);
            chk("hold_busy", 32'(o_busy), 32'd1);
            @(negedge clk);
         end
         chk("run_cpu_rst", 32'(o_crst), 32'd0);
         chk("run_done", 32'(o_done), 32'd1);
         chk("run_busy", 32'(o_busy), 32'd0);
         chk("run_overflow", 32'(o_ovf), 32'd0);
         chk("run_in_ready", 32'(o_ready), 32'd0);
         chk("run_word_count", 32'(o_wc), 32'(n));
      end
      for (int k = 0; k < 4 * n; k++) begin
         chk("im_content", 32'(dut_mem(k)), 32'(exp_mem(k)));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      int cnt;
      rst = 1'b1;
      sel = 1'b0;
      ls  = 1'b0;
      vld = 1'b0;
      dat = 32'd0;
      lst = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values on both instances
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1);
         #1;
         chk("rst_cpu_rst", 32'(o_crst), 32'd1);
         chk("rst_in_ready", 32'(o_ready), 32'd0);
         chk("rst_im_we", 32'(o_we), 32'd0);
         chk("rst_busy", 32'(o_busy), 32'd0);
         chk("rst_done", 32'(o_done), 32'd0);
         chk("rst_overflow", 32'(o_ovf), 32'd0);
         chk("rst_word_count", 32'(o_wc), 32'd0);
         chk("rst_im_addr", 32'(o_addr), 32'd0);
         chk("rst_im_wdata", 32'(o_wd), 32'd0);
      end
      sel = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single word with last: release five edges after the final byte
      load_words(1, 1'b1, 0, 1'b1, 32'h0109_5021);

      // Restart from RUN with a new single-word image
      load_words(1, 1'b1, 0, 1'b1, 32'h3c0a_1234);

      // Backpressure: valid alternates every other cycle
      load_words(3, 1'b1, 1, 1'b0, 32'd0);

      // Random images of random length and valid pattern
      for (int r = 0; r < 4; r++) begin
         load_words($urandom_range(1, 6), 1'b1, $urandom_range(0, 2), 1'b0, 32'd0);
      end

      // Overflow on the 16-byte instance
      sel = 1'b1;
      load_words(4, 1'b0, 0, 1'b0, 32'd0);
      chk("full_overflow", 32'(o_ovf), 32'd1);
      chk("full_in_ready", 32'(o_ready), 32'd0);
      chk("full_cpu_rst", 32'(o_crst), 32'd1);
      chk("full_busy", 32'(o_busy), 32'd0);
      chk("full_word_count", 32'(o_wc), 32'd4);
      cnt = 0;
      dat = $urandom();
      vld = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (o_ready || o_we) cnt++;
      end
      vld = 1'b0;
      chk("fifth_word_rejected", 32'(cnt), 32'd0);
      chk("full_persists", 32'(o_ovf), 32'd1);
      for (int k = 0; k < 16; k++) begin
         chk("full_im_content", 32'(dut_mem(k)), 32'(exp_mem(k)));
      end

      // Exact fit: last word fills memory and the core is released
      load_words(4, 1'b1, 2, 1'b0, 32'd0);

      // Reset in the middle of a word on the default instance
      sel = 1'b0;
      @(negedge clk);
      start_load();
      w = $urandom();
      send_word(w, 1'b1, 0, 0, 2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_im_we", 32'(o_we), 32'd0);
      chk("midrst_cpu_rst", 32'(o_crst), 32'd1);
      chk("midrst_in_ready", 32'(o_ready), 32'd0);
      chk("midrst_busy", 32'(o_busy), 32'd0);
      chk("midrst_done", 32'(o_done), 32'd0);
      chk("midrst_overflow", 32'(o_ovf), 32'd0);
      chk("midrst_word_count", 32'(o_wc), 32'd0);
      chk("midrst_im_addr", 32'(o_addr), 32'd0);
      chk("midrst_im_wdata", 32'(o_wd), 32'd0);
      for (int k = 0; k < 4; k++) begin
         chk("midrst_im_content", 32'(dut_mem(k)), 32'(exp_mem(k)));
      end
      @(negedge clk);
      rst = 1'b0;
      dat = $urandom();
      vld = 1'b1;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (o_ready || o_we || !o_crst) cnt++;
      end
      vld = 1'b0;
      chk("idle_after_reset", 32'(cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
